// File: rtl/vai_c0_rr_arb_if.sv
// vai_c0_rr_arb_if: CCI-P c0 request fan-in bus between sub-AFU requesters and the upstream port
interface vai_c0_rr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 74,
  parameter int SRC_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*HDR_W-1:0] req_hdr;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     up_almFull;
  logic                     out_valid;
  logic [HDR_W-1:0]         out_hdr;
  logic [SRC_W-1:0]         out_src;
  modport slave (
    input  req_valid, req_hdr, up_almFull,
    output req_ready, out_valid, out_hdr, out_src
  );
  modport master (
    output req_valid, req_hdr, up_almFull,
    input  req_ready, out_valid, out_hdr, out_src
  );
endinterface

// File: rtl/vai_c0_rr_arb.sv
// vai_c0_rr_arb: round-robin arbiter merging sub-AFU c0 requests onto one registered upstream port.
// Optional per-requester grant counters are enabled by defining VAI_C0_ARB_GRANT_CNT_EN.
module vai_c0_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 74,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic pClk,
  input  logic pck_cp2af_softReset_n,
  vai_c0_rr_arb_if.slave bus
`ifdef VAI_C0_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0] grant_cnt
`endif
);
  logic [SRC_W-1:0]   lastGrant;
  logic [SRC_W-1:0]   grantIdx;
  logic               anyValid;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  logic [HDR_W-1:0]   grantHdr;
  // Search downward from the farthest slot so the nearest valid requester after lastGrant wins.
  always_comb begin
    grantIdx = '0;
    anyValid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(lastGrant) + k) % NUM_REQ]) begin
        grantIdx = SRC_W'((int'(lastGrant) + k) % NUM_REQ);
        anyValid = 1'b1;
      end
    end
  end
  // Grant is blocked by backpressure and by reset so nothing is taken that cannot be issued.
  always_comb begin
    accept = anyValid && !bus.up_almFull && pck_cp2af_softReset_n;
    ready  = accept ? NUM_REQ'(1) << grantIdx : '0;
  end
  assign bus.req_ready = ready;
  // Tag the top of mdata with the source index so responses can be routed back.
  always_comb begin
    grantHdr = bus.req_hdr[grantIdx*HDR_W +: HDR_W];
    grantHdr[15 -: SRC_W] = grantIdx;
  end
  // Output register: valid follows accept, header/source hold between accepts.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_hdr   <= '0;
      bus.out_src   <= '0;
      lastGrant     <= SRC_W'(NUM_REQ - 1);
    end else begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_hdr <= grantHdr;
        bus.out_src <= grantIdx;
        lastGrant   <= grantIdx;
      end
    end
  end
`ifdef VAI_C0_ARB_GRANT_CNT_EN
  // Free-running 32-bit accept counters per requester, wrapping naturally.
  always_ff @(posedge pClk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pck_cp2af_softReset_n)
        grant_cnt[i*32 +: 32] <= '0;
      else if (bus.req_valid[i] && ready[i])
        grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vai_c0_rr_arb.sv
// tb_vai_c0_rr_arb: directed self-checking bench for the c0 round-robin arbiter
module tb_vai_c0_rr_arb;
  localparam int NUM_REQ = 4;
  localparam int HDR_W   = 74;
  localparam int SRC_W   = 2;
  logic pClk = 1'b0;
  logic rstN;
  int nAssert = 0;
  int nFail = 0;
  logic [HDR_W-1:0] hdrTab [4] = '{
    74'h011_1111_1111_1111_FFFF,
    74'h022_2222_2222_2222_0FFF,
    74'h033_3333_3333_3333_0FFF,
    74'h044_4444_4444_4444_0FFF
  };
  logic [15:0] expLow [4] = '{16'h3FFF, 16'h4FFF, 16'h8FFF, 16'hCFFF};
  vai_c0_rr_arb_if #(.NUM_REQ(NUM_REQ), .HDR_W(HDR_W), .SRC_W(SRC_W)) bus ();
`ifdef VAI_C0_ARB_GRANT_CNT_EN
  logic [NUM_REQ*32-1:0] grantCnt;
`endif
  vai_c0_rr_arb #(.NUM_REQ(NUM_REQ), .HDR_W(HDR_W), .SRC_W(SRC_W)) dut (
    .pClk(pClk),
    .pck_cp2af_softReset_n(rstN),
    .bus(bus)
`ifdef VAI_C0_ARB_GRANT_CNT_EN
    ,
    .grant_cnt(grantCnt)
`endif
  );
  always #5 pClk = ~pClk;
  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge pClk);
    #1;
  endtask
  task automatic setHdrs;
    for (int i = 0; i < NUM_REQ; i++) bus.req_hdr[i*HDR_W +: HDR_W] = hdrTab[i];
  endtask
  function automatic logic [HDR_W-1:0] expHdr(input int g);
    return {hdrTab[g][HDR_W-1:16], expLow[g]};
  endfunction
  initial begin
    rstN = 1'b0;
    bus.req_valid = 4'hF;
    bus.up_almFull = 1'b0;
    setHdrs();
    #1;
    checkEq("ready_in_reset", bus.req_ready, 0);
    step();
    step();
    checkEq("rst_out_valid", bus.out_valid, 0);
    checkEq("rst_out_hdr", bus.out_hdr, 0);
    checkEq("rst_out_src", bus.out_src, 0);
    rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkEq("rr_ready", bus.req_ready, 1 << (k % 4));
      step();
      checkEq("rr_out_valid", bus.out_valid, 1);
      checkEq("rr_out_src", bus.out_src, k % 4);
      checkEq("rr_out_hdr", bus.out_hdr, expHdr(k % 4));
    end
    bus.up_almFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkEq("af_ready", bus.req_ready, 0);
      step();
      checkEq("af_out_valid", bus.out_valid, 0);
      checkEq("af_out_src_hold", bus.out_src, 1);
    end
    bus.up_almFull = 1'b0;
    #1;
    checkEq("af_resume_ready", bus.req_ready, 4'b0100);
    step();
    checkEq("af_resume_valid", bus.out_valid, 1);
    checkEq("af_resume_src", bus.out_src, 2);
    bus.req_valid = 4'b0100;
    bus.req_hdr[2*HDR_W +: HDR_W] = 74'h2AB_CDEF_0123_4567_0000;
    #1;
    checkEq("single_ready", bus.req_ready, 4'b0100);
    step();
    checkEq("single_out_hdr", bus.out_hdr, 74'h2AB_CDEF_0123_4567_8000);
    checkEq("single_out_src", bus.out_src, 2);
    setHdrs();
    bus.req_valid = 4'b0000;
    #1;
    checkEq("idle_ready", bus.req_ready, 0);
    step();
    checkEq("idle_out_valid", bus.out_valid, 0);
    checkEq("idle_hdr_hold", bus.out_hdr, 74'h2AB_CDEF_0123_4567_8000);
    bus.req_valid = 4'b0001;
    #1;
    checkEq("solo0_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b1001;
    #1;
    checkEq("wrap_ready3", bus.req_ready, 4'b1000);
    step();
    checkEq("wrap_src3", bus.out_src, 3);
    #1;
    checkEq("wrap_ready0", bus.req_ready, 4'b0001);
    step();
    checkEq("wrap_src0", bus.out_src, 0);
    checkEq("wrap_valid", bus.out_valid, 1);
    bus.req_valid = 4'hF;
    #1;
    checkEq("pre_rst_ready", bus.req_ready, 4'b0010);
    step();
    checkEq("pre_rst_src", bus.out_src, 1);
    rstN = 1'b0;
    #1;
    checkEq("mid_rst_ready", bus.req_ready, 0);
    step();
    checkEq("mid_rst_valid", bus.out_valid, 0);
    checkEq("mid_rst_src", bus.out_src, 0);
    rstN = 1'b1;
    #1;
    checkEq("post_rst_ready", bus.req_ready, 4'b0001);
    step();
    checkEq("post_rst_src", bus.out_src, 0);
    checkEq("post_rst_valid", bus.out_valid, 1);
`ifdef VAI_C0_ARB_GRANT_CNT_EN
    rstN = 1'b0;
    step();
    checkEq("cnt_rst", grantCnt, 0);
    rstN = 1'b1;
    repeat (100) step();
    for (int i = 0; i < NUM_REQ; i++) checkEq("grant_cnt", grantCnt[i*32 +: 32], 25);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/vai_c0_rr_arb.md
VAI_C0_RR_ARB -- requirements
Module: vai_c0_rr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of sub-AFU requesters (legal range 2..16).
REQ-002 The block SHALL have parameter HDR_W, default 74, giving the width of the CCI-P c0 request header.
REQ-003 The block SHALL have parameter SRC_W, default $clog2(NUM_REQ), giving the width of the source-ID field.
REQ-004 pClk  input  1  sole clock; every flop is rising-edge.
REQ-005 pck_cp2af_softReset_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester c0 request valid.
REQ-007 req_hdr  input  NUM_REQ*HDR_W  per-requester header; requester i occupies bits [i*HDR_W +: HDR_W].
REQ-008 req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero.
REQ-009 up_almFull  input  1  upstream c0TxAlmFull.
REQ-010 out_valid  output  1  registered upstream c0 request valid.
REQ-011 out_hdr  output  HDR_W  registered upstream header.
REQ-012 out_src  output  SRC_W  registered index of the granted requester.

Function
REQ-013 The block SHALL accept a request from requester i in a cycle iff req_valid[i] and req_ready[i] are both high.
REQ-014 The block SHALL hold req_ready at all zeros while up_almFull=1, while in reset, and when no req_valid bit is set.
REQ-015 When up_almFull=0 and at least one req_valid bit is set, the block SHALL assert exactly one req_ready bit, for the first valid requester searching upward from (last_grant+1) mod NUM_REQ.
REQ-016 last_grant SHALL update to the accepted index on each accept and SHALL hold otherwise.
REQ-017 A requester continuously valid SHALL be granted within NUM_REQ accept cycles.
REQ-018 Latency: an accept at cycle N SHALL produce out_valid=1 at cycle N+1, and out_valid SHALL be 0 in any cycle following a non-accept cycle.
REQ-019 out_hdr SHALL equal the accepted header with bits [15 -: SRC_W] (top of mdata) overwritten by the granted index; all other bits SHALL pass unchanged.
REQ-020 out_src SHALL equal the granted index.
REQ-021 out_hdr and out_src SHALL hold their last value when out_valid=0.
REQ-022 The block SHALL not buffer requests; a request not granted SHALL stay on the requester's port until it is granted.
REQ-023 If up_almFull rises in the same cycle as a valid request, that request SHALL NOT be granted.
REQ-024 A request accepted in the cycle before up_almFull rises SHALL still be issued.
REQ-025 The search SHALL wrap from index NUM_REQ-1 to index 0.

Reset
REQ-026 While pck_cp2af_softReset_n=0 at a pClk edge, the block SHALL set out_valid=0, out_hdr=0, out_src=0 and last_grant=NUM_REQ-1, so that requester 0 has priority first.
REQ-027 A reset asserted mid-stream SHALL drop any pending output on the next edge, with no request issued.
REQ-028 On the first cycle after reset release, grants SHALL follow REQ-015.

Configuration
REQ-029 Macro VAI_C0_ARB_GRANT_CNT_EN SHALL control a per-requester grant counter.
REQ-030 With VAI_C0_ARB_GRANT_CNT_EN defined, the block SHALL add output grant_cnt (NUM_REQ*32, requester i at [i*32 +: 32]).
REQ-031 grant_cnt SHALL increment by 1 for each accept, SHALL reset to 0, and SHALL wrap at 2^32.
REQ-032 grant_cnt SHALL have no effect on arbitration.
REQ-033 Without VAI_C0_ARB_GRANT_CNT_EN, the port and its counters SHALL be absent.

Verification
REQ-034 After reset, all four req_valid bits held high with up_almFull=0 -> grants SHALL go 0,1,2,3,0,... one per cycle; out_valid SHALL be 1 from cycle 2; out_src SHALL match the grant delayed one cycle.
REQ-035 Only req_valid[2] high, req_hdr[2] mdata=16'h0000 -> out_hdr[15:14]=2'b10 and all other bits equal to the input.
REQ-036 up_almFull=1 for 5 cycles while all requesters are valid -> req_ready=0 and, from the 2nd cycle, out_valid=0; on release the grant SHALL resume at last_grant+1.
REQ-037 Reset asserted for 1 cycle mid-stream -> next cycle out_valid=0, and the first grant after release SHALL go to requester 0.
REQ-038 req_valid={1,0,0,1} (bits 3..0) with last_grant=0 -> grant SHALL go to 3, then wrap to 0.
REQ-039 With VAI_C0_ARB_GRANT_CNT_EN, 100 cycles of all requesters valid -> each grant_cnt SHALL equal 25.
